vaccine_score_manager: RTL and testbench

VACCINE_SCORE_MANAGER -- requirements
Module: vaccine_score_manager

---
 rtl/game_pkg.sv | 12 +
 rtl/sat_score_counter.sv | 34 +++
 rtl/vaccine_score_manager.sv | 123 ++++++++++++
 tb/tb_vaccine_score_manager.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared object count, score limit, hit decoding and FSM state type.
package game_pkg;
    localparam int         NUM_OBJECTS = 10;
    localparam logic [3:0] NO_HIT      = 4'd15;
    localparam int         SCORE_MAX   = 999;

    typedef enum logic [2:0] {IDLE, PLAY, COMMIT, DONE, GAME_OVER} game_state_t;

    function automatic logic idx_valid(input logic [3:0] idx);
        return (idx != NO_HIT) && (idx < 4'(NUM_OBJECTS));
    endfunction
endpackage

// File: rtl/sat_score_counter.sv
// sat_score_counter: score register; add then subtract in one step, clamped to 0..SCORE_MAX.
module sat_score_counter
    import game_pkg::*;
#(
    parameter int ADD = 5,
    parameter int SUB = 3
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic       i_add_en,
    input  logic       i_sub_en,
    output logic [9:0] o_score
);
    logic [10:0] w_sum;
    logic [9:0]  w_cap;
    logic [9:0]  w_next;

    always_comb begin
        w_sum  = {1'b0, o_score} + (i_add_en ? 11'(ADD) : 11'd0);
        w_cap  = (w_sum > 11'(SCORE_MAX)) ? 10'(SCORE_MAX) : w_sum[9:0];
        w_next = !i_sub_en ? w_cap : (w_cap < 10'(SUB)) ? 10'd0 : w_cap - 10'(SUB);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            o_score <= 10'd0;
        else if (i_clear)
            o_score <= 10'd0;
        else if (i_en)
            o_score <= w_next;
    end
endmodule

// File: rtl/vaccine_score_manager.sv
// vaccine_score_manager: per-frame vaccine/corona hit latching, mask, score and lives FSM.
module vaccine_score_manager
    import game_pkg::*;
#(
    parameter logic [0:NUM_OBJECTS-1] INIT_VACCINES  = 10'b11_1111_1111,
    parameter int                     VACCINE_POINTS = 5,
    parameter int                     CORONA_PENALTY = 3,
    parameter logic [1:0]             INIT_LIVES     = 2'd3
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   startGame,
    input  logic [3:0]             collision_clamp_vaccine,
    input  logic [3:0]             collision_clamp_corona,
    output logic [0:NUM_OBJECTS-1] current_vaccines,
    output logic [9:0]             score,
    output logic [1:0]             lives,
    output logic                   capturePulse,
    output logic                   hitPulse,
    output logic                   gameOver,
    output logic                   phaseDone
);
    game_state_t r_state;
    logic [3:0]  r_pend_vac;
    logic        r_pend_vac_v;
    logic        r_pend_cor_v;
    logic        w_vac_hit;
    logic        w_cor_hit;
    logic        w_start;
    logic        w_sof_commit;
    logic        w_capture;

    assign w_vac_hit    = idx_valid(collision_clamp_vaccine);
    assign w_cor_hit    = idx_valid(collision_clamp_corona);
    assign w_start      = startGame && (r_state == IDLE || r_state == DONE || r_state == GAME_OVER);
    assign w_sof_commit = startOfFrame && (r_state == PLAY);
    assign w_capture    = r_pend_vac_v && current_vaccines[r_pend_vac];

    // The update lands on the startOfFrame edge; COMMIT is the cycle that shows it and picks the next state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state          <= IDLE;
            current_vaccines <= INIT_VACCINES;
            lives            <= INIT_LIVES;
            capturePulse     <= 1'b0;
            hitPulse         <= 1'b0;
            gameOver         <= 1'b0;
            phaseDone        <= 1'b0;
        end else begin
            capturePulse <= 1'b0;
            hitPulse     <= 1'b0;
            case (r_state)
                IDLE, DONE, GAME_OVER: if (startGame) begin
                    r_state          <= PLAY;
                    current_vaccines <= INIT_VACCINES;
                    lives            <= INIT_LIVES;
                    gameOver         <= 1'b0;
                    phaseDone        <= 1'b0;
                end
                PLAY: if (startOfFrame) begin
                    r_state <= COMMIT;
                    if (w_capture) begin
                        current_vaccines[r_pend_vac] <= 1'b0;
                        capturePulse                 <= 1'b1;
                    end
                    if (r_pend_cor_v) begin
                        lives    <= (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                        hitPulse <= 1'b1;
                    end
                end
                COMMIT: begin
                    if (lives == 2'd0) begin
                        r_state  <= GAME_OVER;
                        gameOver <= 1'b1;
                    end else if (current_vaccines == '0) begin
                        r_state   <= DONE;
                        phaseDone <= 1'b1;
                    end else
                        r_state <= PLAY;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A hit coincident with startOfFrame seeds the next frame's latches.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_pend_vac   <= NO_HIT;
            r_pend_vac_v <= 1'b0;
            r_pend_cor_v <= 1'b0;
        end else if (w_start) begin
            r_pend_vac   <= NO_HIT;
            r_pend_vac_v <= 1'b0;
            r_pend_cor_v <= 1'b0;
        end else if (w_sof_commit) begin
            r_pend_vac   <= collision_clamp_vaccine;
            r_pend_vac_v <= w_vac_hit;
            r_pend_cor_v <= w_cor_hit;
        end else if (r_state == PLAY || r_state == COMMIT) begin
            if (!r_pend_vac_v && w_vac_hit) begin
                r_pend_vac   <= collision_clamp_vaccine;
                r_pend_vac_v <= 1'b1;
            end
            if (w_cor_hit)
                r_pend_cor_v <= 1'b1;
        end
    end

    sat_score_counter #(
        .ADD(VACCINE_POINTS),
        .SUB(CORONA_PENALTY)
    ) u_score (
        .clk     (clk),
        .resetN  (resetN),
        .i_clear (w_start),
        .i_en    (w_sof_commit),
        .i_add_en(w_capture),
        .i_sub_en(r_pend_cor_v),
        .o_score (score)
    );
endmodule

// File: tb/tb_vaccine_score_manager.sv
// tb_vaccine_score_manager: directed vectors with hand-computed mask/score/lives expectations.
module tb_vaccine_score_manager;
    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       startGame;
    logic [3:0] vac;
    logic [3:0] cor;
    logic [0:9] current_vaccines;
    logic [9:0] score;
    logic [1:0] lives;
    logic       capturePulse;
    logic       hitPulse;
    logic       gameOver;
    logic       phaseDone;
    int         n_tests = 0;
    int         n_fail  = 0;

    vaccine_score_manager dut (
        .clk                    (clk),
        .resetN                 (resetN),
        .startOfFrame           (startOfFrame),
        .startGame              (startGame),
        .collision_clamp_vaccine(vac),
        .collision_clamp_corona (cor),
        .current_vaccines       (current_vaccines),
        .score                  (score),
        .lives                  (lives),
        .capturePulse           (capturePulse),
        .hitPulse               (hitPulse),
        .gameOver               (gameOver),
        .phaseDone              (phaseDone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        startGame = 1'b1;
        step();
        startGame = 1'b0;
    endtask

    task automatic hit(input logic [3:0] v, input logic [3:0] c);
        vac = v;
        cor = c;
        step();
        vac = 4'd15;
        cor = 4'd15;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        #1;
        step();
        resetN = 1'b1;
        step();
    endtask

    task automatic state_chk(input string tag, input logic [9:0] m, input logic [9:0] s, input logic [1:0] l,
                             input logic cp, input logic hp);
        check({tag, "_mask"}, 32'(current_vaccines), 32'(m));
        check({tag, "_score"}, 32'(score), 32'(s));
        check({tag, "_lives"}, 32'(lives), 32'(l));
        check({tag, "_cap"}, 32'(capturePulse), 32'(cp));
        check({tag, "_hit"}, 32'(hitPulse), 32'(hp));
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; startGame = 1'b0; vac = 4'd15; cor = 4'd15;
        repeat (3) step();
        state_chk("rst", 10'b1111111111, 10'd0, 2'd3, 1'b0, 1'b0);
        check("rst_gameover", 32'(gameOver), 32'd0);
        check("rst_done", 32'(phaseDone), 32'd0);
        resetN = 1'b1;
        step();

        // single capture of vaccine 3
        start();
        hit(4'd3, 4'd15);
        sof();
        state_chk("cap3", 10'b1110111111, 10'd5, 2'd3, 1'b1, 1'b0);
        step();
        check("cap3_pulse_end", 32'(capturePulse), 32'd0);
        start();
        state_chk("start_in_play", 10'b1110111111, 10'd5, 2'd3, 1'b0, 1'b0);

        // first hit per frame wins; repeat target gives nothing
        do_reset();
        start();
        hit(4'd2, 4'd15);
        hit(4'd7, 4'd15);
        sof();
        state_chk("first_hit", 10'b1101111111, 10'd5, 2'd3, 1'b1, 1'b0);
        step();
        hit(4'd2, 4'd15);
        sof();
        state_chk("repeat_hit", 10'b1101111111, 10'd5, 2'd3, 1'b0, 1'b0);
        step();

        // combined vaccine + corona, then floor at 0
        do_reset();
        start();
        hit(4'd0, 4'd4);
        sof();
        state_chk("both", 10'b0111111111, 10'd2, 2'd2, 1'b1, 1'b1);
        step();
        hit(4'd15, 4'd1);
        sof();
        state_chk("floor", 10'b0111111111, 10'd0, 2'd1, 1'b0, 1'b1);
        step();

        // three corona hits -> game over, then inputs ignored
        do_reset();
        start();
        for (int i = 0; i < 3; i++) begin
            hit(4'd15, 4'(i));
            sof();
            state_chk("cor", 10'b1111111111, 10'd0, 2'(2 - i), 1'b0, 1'b1);
            check("cor_go_early", 32'(gameOver), 32'd0);
            step();
        end
        check("gameover", 32'(gameOver), 32'd1);
        hit(4'd0, 4'd0);
        sof();
        state_chk("go_ignore", 10'b1111111111, 10'd0, 2'd0, 1'b0, 1'b0);
        check("go_hold", 32'(gameOver), 32'd1);

        // capture all ten -> DONE, then restart
        do_reset();
        start();
        for (int i = 0; i < 10; i++) begin
            hit(4'(i), 4'd15);
            sof();
            if (i != 9) step();
        end
        state_chk("all", 10'b0000000000, 10'd50, 2'd3, 1'b1, 1'b0);
        check("all_done_early", 32'(phaseDone), 32'd0);
        step();
        check("all_done", 32'(phaseDone), 32'd1);
        start();
        state_chk("restart", 10'b1111111111, 10'd0, 2'd3, 1'b0, 1'b0);
        check("restart_done", 32'(phaseDone), 32'd0);
        hit(4'd1, 4'd15);
        sof();
        state_chk("restart_play", 10'b1011111111, 10'd5, 2'd3, 1'b1, 1'b0);
        step();

        // coincident-with-SOF and during-COMMIT hits belong to the next frame
        do_reset();
        start();
        vac = 4'd5;
        sof();
        vac = 4'd15;
        state_chk("coinc_now", 10'b1111111111, 10'd0, 2'd3, 1'b0, 1'b0);
        step();
        sof();
        state_chk("coinc_next", 10'b1111101111, 10'd5, 2'd3, 1'b1, 1'b0);
        hit(4'd6, 4'd15);
        sof();
        state_chk("commit_hit", 10'b1111100111, 10'd10, 2'd3, 1'b1, 1'b0);
        step();
        hit(4'd12, 4'd10);
        sof();
        state_chk("idx_10_14", 10'b1111100111, 10'd10, 2'd3, 1'b0, 1'b0);
        step();

        // reset during COMMIT
        hit(4'd1, 4'd2);
        sof();
        state_chk("pre_rst", 10'b1011100111, 10'd12, 2'd2, 1'b1, 1'b1);
        vac = 4'd8;
        cor = 4'd3;
        resetN = 1'b0;
        #1;
        state_chk("rst_commit", 10'b1111111111, 10'd0, 2'd3, 1'b0, 1'b0);
        step();
        vac = 4'd15;
        cor = 4'd15;
        resetN = 1'b1;
        step();
        start();
        sof();
        state_chk("post_rst", 10'b1111111111, 10'd0, 2'd3, 1'b0, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
